// File: rtl/sdram_burst_master.sv
// rtl/sdram_burst_master.sv - burst request initiator for the SDRAM controller
// Arbitrates FIFO-level-driven write/read bursts over two circular address regions.
module sdram_burst_master #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 1024,
  parameter int LVL_WIDTH  = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdram_init_done,
  input  logic [23:0]          wr_min_addr,
  input  logic [23:0]          wr_max_addr,
  input  logic [9:0]           wr_len,
  input  logic                 wr_load,
  input  logic [LVL_WIDTH-1:0] wr_fifo_level,
  output logic                 wr_fifo_rdreq,
  input  logic [23:0]          rd_min_addr,
  input  logic [23:0]          rd_max_addr,
  input  logic [9:0]           rd_len,
  input  logic                 rd_load,
  input  logic                 rd_en,
  input  logic [LVL_WIDTH-1:0] rd_fifo_level,
  output logic                 rd_fifo_wrreq,
  output logic                 sdram_wr_req,
  input  logic                 sdram_wr_ack,
  output logic [23:0]          sdram_wr_addr,
  output logic [9:0]           sdram_wr_burst,
  output logic                 sdram_rd_req,
  input  logic                 sdram_rd_ack,
  output logic [23:0]          sdram_rd_addr,
  output logic [9:0]           sdram_rd_burst
);

  localparam int LW1 = LVL_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_BURST, S_RD_REQ, S_RD_BURST} state_t;

  if (DATA_WIDTH < 1 || LVL_WIDTH < 10) begin : g_param_check
    $error("sdram_burst_master: unsupported DATA_WIDTH or LVL_WIDTH");
  end

  state_t      r_state;
  logic [23:0] r_wr_ptr, r_rd_ptr;
  logic        r_wr_req, r_rd_req;
  logic        r_last_wr;
  logic        r_wr_load_d, r_rd_load_d;
  logic        r_wr_pend, r_rd_pend;
  logic        r_wr_ack_d, r_rd_ack_d;

  logic           w_wr_ok, w_rd_ok;
  logic [LW1-1:0] w_rd_sum;
  logic [24:0]    w_wr_next, w_wr_end, w_rd_next, w_rd_end;
  logic [23:0]    w_wr_adv, w_rd_adv;
  logic           w_wr_load_rise, w_rd_load_rise;
  logic           w_wr_done, w_rd_done;

  // Read-side sum is one bit wider so a nearly full FIFO cannot wrap into eligibility.
  assign w_rd_sum = LW1'(rd_fifo_level) + LW1'(rd_len);
  assign w_wr_ok  = sdram_init_done && (wr_fifo_level >= LVL_WIDTH'(wr_len));
  assign w_rd_ok  = sdram_init_done && rd_en && (w_rd_sum <= LW1'(FIFO_DEPTH));

  assign w_wr_next = {1'b0, r_wr_ptr} + 25'(wr_len);
  assign w_wr_end  = w_wr_next + 25'(wr_len);
  assign w_wr_adv  = (w_wr_end > {1'b0, wr_max_addr}) ? wr_min_addr : w_wr_next[23:0];
  assign w_rd_next = {1'b0, r_rd_ptr} + 25'(rd_len);
  assign w_rd_end  = w_rd_next + 25'(rd_len);
  assign w_rd_adv  = (w_rd_end > {1'b0, rd_max_addr}) ? rd_min_addr : w_rd_next[23:0];

  assign w_wr_load_rise = wr_load & ~r_wr_load_d;
  assign w_rd_load_rise = rd_load & ~r_rd_load_d;
  assign w_wr_done      = r_wr_ack_d & ~sdram_wr_ack;
  assign w_rd_done      = r_rd_ack_d & ~sdram_rd_ack;

  // Pass-through outputs are gated so every output reads 0 while reset is held.
  assign wr_fifo_rdreq  = rst_n & sdram_wr_ack;
  assign rd_fifo_wrreq  = rst_n & sdram_rd_ack;
  assign sdram_wr_burst = rst_n ? wr_len : 10'd0;
  assign sdram_rd_burst = rst_n ? rd_len : 10'd0;
  assign sdram_wr_addr  = r_wr_ptr;
  assign sdram_rd_addr  = r_rd_ptr;
  assign sdram_wr_req   = r_wr_req;
  assign sdram_rd_req   = r_rd_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= 24'd0;
      r_rd_ptr    <= 24'd0;
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_last_wr   <= 1'b0;
      r_wr_load_d <= 1'b0;
      r_rd_load_d <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr_ack_d  <= 1'b0;
      r_rd_ack_d  <= 1'b0;
    end else begin
      r_wr_load_d <= wr_load;
      r_rd_load_d <= rd_load;
      r_wr_ack_d  <= sdram_wr_ack;
      r_rd_ack_d  <= sdram_rd_ack;

      // Rewinds wait for IDLE so a load during a burst lands once that burst is done.
      if (r_state == S_IDLE && r_wr_pend) begin
        r_wr_ptr  <= wr_min_addr;
        r_wr_pend <= 1'b0;
      end
      if (r_state == S_IDLE && r_rd_pend) begin
        r_rd_ptr  <= rd_min_addr;
        r_rd_pend <= 1'b0;
      end
      if (w_wr_load_rise) r_wr_pend <= 1'b1;
      if (w_rd_load_rise) r_rd_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_wr_ok && (!w_rd_ok || !r_last_wr)) begin
            r_wr_req <= 1'b1;
            r_state  <= S_WR_REQ;
          end else if (w_rd_ok) begin
            r_rd_req <= 1'b1;
            r_state  <= S_RD_REQ;
          end
        end
        S_WR_REQ: begin
          if (sdram_wr_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= S_WR_BURST;
          end
        end
        S_WR_BURST: begin
          if (w_wr_done) begin
            r_wr_ptr  <= w_wr_adv;
            r_last_wr <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (sdram_rd_ack) begin
            r_rd_req <= 1'b0;
            r_state  <= S_RD_BURST;
          end
        end
        S_RD_BURST: begin
          if (w_rd_done) begin
            r_rd_ptr  <= w_rd_adv;
            r_last_wr <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_master.sv
// tb/tb_sdram_burst_master.sv - directed vector bench for sdram_burst_master
// Eligibility and burst-address tables plus hand sequences for load, full-FIFO and reset.
module tb_sdram_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_init_done = 1'b1;
  logic [23:0] wr_min_addr = 24'd0, wr_max_addr = 24'd2048;
  logic [9:0]  wr_len = 10'd512;
  logic        wr_load = 1'b0;
  logic [10:0] wr_fifo_level = 11'd0;
  logic        wr_fifo_rdreq;
  logic [23:0] rd_min_addr = 24'd0, rd_max_addr = 24'd4096;
  logic [9:0]  rd_len = 10'd256;
  logic        rd_load = 1'b0;
  logic        rd_en = 1'b0;
  logic [10:0] rd_fifo_level = 11'd0;
  logic        rd_fifo_wrreq;
  logic        sdram_wr_req, sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic        sdram_rd_req, sdram_rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;

  int n_vec = 0;
  int n_err = 0;
  int n_overlap = 0;

  sdram_burst_master #(.DATA_WIDTH(16), .FIFO_DEPTH(1024), .LVL_WIDTH(11)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr), .wr_len(wr_len),
    .wr_load(wr_load), .wr_fifo_level(wr_fifo_level), .wr_fifo_rdreq(wr_fifo_rdreq),
    .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr), .rd_len(rd_len),
    .rd_load(rd_load), .rd_en(rd_en), .rd_fifo_level(rd_fifo_level),
    .rd_fifo_wrreq(rd_fifo_wrreq),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sdram_wr_req && sdram_rd_req) n_overlap++;

  typedef struct {
    logic [10:0] wr_lvl;
    logic        en;
    logic [10:0] rd_lvl;
    logic        init;
    logic        exp_wr;
    logic        exp_rd;
  } elig_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic        is_rd;
    logic [23:0] wmax;
    logic [23:0] exp_addr;
    logic [23:0] exp_next;
  } burst_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic req_of(input bit r);
    return r ? sdram_rd_req : sdram_wr_req;
  endfunction

  function automatic logic [23:0] addr_of(input bit r);
    return r ? sdram_rd_addr : sdram_wr_addr;
  endfunction

  function automatic logic push_of(input bit r);
    return r ? rd_fifo_wrreq : wr_fifo_rdreq;
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    wr_load = 1'b0;
    rd_load = 1'b0;
    @(negedge clk);
    if (chk) begin
      check("reset wr_req", sdram_wr_req, 0);
      check("reset rd_req", sdram_rd_req, 0);
      check("reset wr_addr", sdram_wr_addr, 0);
      check("reset rd_addr", sdram_rd_addr, 0);
      check("reset wr_burst", sdram_wr_burst, 0);
      check("reset rd_burst", sdram_rd_burst, 0);
      check("reset fifo strobes", {wr_fifo_rdreq, rd_fifo_wrreq}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a request, acks it 3 cycles later for len cycles, checks address, pops and advance.
  task automatic burst(input bit is_rd, input logic [23:0] exp_addr, input logic [23:0] exp_next,
                       input int len, input bit pulse_load, input string tag);
    int k = 0;
    int cnt = 0;
    while (!req_of(is_rd) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req seen"}, req_of(is_rd), 1);
    if (!req_of(is_rd)) return;
    check({tag, " addr"}, addr_of(is_rd), exp_addr);
    check({tag, " other req low"}, req_of(!is_rd), 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < len + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (is_rd) sdram_rd_ack = (i < len);
      else       sdram_wr_ack = (i < len);
      rd_load = pulse_load && (i == 0);
      #1;
      cnt += int'(push_of(is_rd));
      if (i == 1) check({tag, " req drops on ack"}, req_of(is_rd), 0);
    end
    check({tag, " fifo strobe cycles"}, cnt, len);
    check({tag, " next addr"}, addr_of(is_rd), exp_next);
    check({tag, " idle gap"}, {sdram_wr_req, sdram_rd_req}, 0);
  endtask

  elig_t  ev[9];
  burst_t bv[11];

  initial begin
    int k;

    ev[0] = '{11'd600,  1'b0, 11'd0,    1'b1, 1'b1, 1'b0};
    ev[1] = '{11'd511,  1'b0, 11'd0,    1'b1, 1'b0, 1'b0};
    ev[2] = '{11'd512,  1'b0, 11'd0,    1'b1, 1'b1, 1'b0};
    ev[3] = '{11'd0,    1'b1, 11'd768,  1'b1, 1'b0, 1'b1};
    ev[4] = '{11'd0,    1'b1, 11'd769,  1'b1, 1'b0, 1'b0};
    ev[5] = '{11'd600,  1'b1, 11'd0,    1'b1, 1'b1, 1'b0};
    ev[6] = '{11'd600,  1'b1, 11'd0,    1'b0, 1'b0, 1'b0};
    ev[7] = '{11'd0,    1'b0, 11'd0,    1'b1, 1'b0, 1'b0};
    ev[8] = '{11'd0,    1'b1, 11'd1900, 1'b1, 1'b0, 1'b0};

    bv[0]  = '{1'b1, 1'b0, 1'b0, 24'd2048, 24'd0,    24'd512};
    bv[1]  = '{1'b0, 1'b0, 1'b0, 24'd2048, 24'd512,  24'd1024};
    bv[2]  = '{1'b0, 1'b0, 1'b0, 24'd2048, 24'd1024, 24'd1536};
    bv[3]  = '{1'b0, 1'b0, 1'b0, 24'd2048, 24'd1536, 24'd0};
    bv[4]  = '{1'b0, 1'b0, 1'b0, 24'd2000, 24'd0,    24'd512};
    bv[5]  = '{1'b0, 1'b0, 1'b0, 24'd2000, 24'd512,  24'd1024};
    bv[6]  = '{1'b0, 1'b0, 1'b0, 24'd2000, 24'd1024, 24'd0};
    bv[7]  = '{1'b1, 1'b1, 1'b0, 24'd2048, 24'd0,    24'd512};
    bv[8]  = '{1'b0, 1'b1, 1'b1, 24'd2048, 24'd0,    24'd256};
    bv[9]  = '{1'b0, 1'b1, 1'b0, 24'd2048, 24'd512,  24'd1024};
    bv[10] = '{1'b0, 1'b1, 1'b1, 24'd2048, 24'd256,  24'd512};

    for (int i = 0; i < 9; i++) begin
      wr_fifo_level   = ev[i].wr_lvl;
      rd_en           = ev[i].en;
      rd_fifo_level   = ev[i].rd_lvl;
      sdram_init_done = ev[i].init;
      do_reset(i == 0);
      repeat (3) @(negedge clk);
      check($sformatf("elig[%0d] wr_req", i), sdram_wr_req, ev[i].exp_wr);
      check($sformatf("elig[%0d] rd_req", i), sdram_rd_req, ev[i].exp_rd);
    end

    sdram_init_done = 1'b1;
    wr_fifo_level = 11'd600;
    rd_fifo_level = 11'd0;
    for (int i = 0; i < 11; i++) begin
      if (bv[i].rst) begin
        rd_en = bv[i].en;
        do_reset(1'b0);
      end
      wr_max_addr = bv[i].wmax;
      burst(bv[i].is_rd, bv[i].exp_addr, bv[i].exp_next,
            bv[i].is_rd ? 256 : 512, 1'b0, $sformatf("burst[%0d]", i));
    end

    // Read FIFO too full, then exactly room for one burst.
    wr_fifo_level = 11'd0;
    rd_en = 1'b1;
    rd_fifo_level = 11'd800;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    check("full fifo rd_req", sdram_rd_req, 0);
    rd_fifo_level = 11'd768;
    k = 0;
    while (!sdram_rd_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("room rd_req latency", (k >= 1 && k <= 2), 1);
    check("room rd_addr", sdram_rd_addr, 0);

    // Load pulsed mid-burst is deferred, then rewinds to rd_min_addr.
    rd_en = 1'b0;
    rd_fifo_level = 11'd0;
    rd_min_addr = 24'd256;
    do_reset(1'b0);
    @(negedge clk); rd_load = 1'b1;
    @(negedge clk); rd_load = 1'b0;
    repeat (2) @(negedge clk);
    rd_en = 1'b1;
    burst(1'b1, 24'd256, 24'd512,  256, 1'b0, "load a");
    burst(1'b1, 24'd512, 24'd768,  256, 1'b0, "load b");
    burst(1'b1, 24'd768, 24'd1024, 256, 1'b1, "load mid");
    burst(1'b1, 24'd256, 24'd512,  256, 1'b0, "load applied");

    // Asynchronous reset in the middle of a write burst.
    rd_en = 1'b0;
    wr_fifo_level = 11'd600;
    wr_max_addr = 24'd2048;
    do_reset(1'b0);
    burst(1'b0, 24'd0, 24'd512, 512, 1'b0, "rst pre");
    k = 0;
    while (!sdram_wr_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst second req", sdram_wr_req, 1);
    check("rst second addr", sdram_wr_addr, 512);
    repeat (2) @(negedge clk);
    sdram_wr_ack = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst wr_req", sdram_wr_req, 0);
    check("async rst wr_addr", sdram_wr_addr, 0);
    check("async rst wr_burst", sdram_wr_burst, 0);
    check("async rst wr_fifo_rdreq", wr_fifo_rdreq, 0);
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    burst(1'b0, 24'd0, 24'd512, 512, 1'b0, "rst post");

    check("req overlap cycles", n_overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_burst_master.md
Name: sdram_burst_master

Overview:
- Initiator that drives the write and read request ports of the team's SDRAM controller.
- Watches the fill levels of an external write FIFO (video-in) and an external read FIFO (video-out) and issues burst requests.
- Keeps independent circular write and read address pointers.
- Routes the ack strobes so they act as FIFO pop and push enables.

Parameters:
- DATA_WIDTH, 16, SDRAM data width.
- FIFO_DEPTH, 1024, read FIFO capacity in words.
- LVL_WIDTH, 11, width of the FIFO level inputs.

Ports:
- clk  in  1  controller clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- sdram_init_done  in  1  controller initialisation complete.
- wr_min_addr  in  24  write region base address.
- wr_max_addr  in  24  write region end address (exclusive).
- wr_len  in  10  write burst length, nonzero.
- wr_load  in  1  rising edge rewinds the write pointer.
- wr_fifo_level  in  LVL_WIDTH  words in the write FIFO.
- wr_fifo_rdreq  out  1  write FIFO pop.
- rd_min_addr  in  24  read region base address.
- rd_max_addr  in  24  read region end address (exclusive).
- rd_len  in  10  read burst length, nonzero.
- rd_load  in  1  rising edge rewinds the read pointer.
- rd_en  in  1  read traffic enable.
- rd_fifo_level  in  LVL_WIDTH  words in the read FIFO.
- rd_fifo_wrreq  out  1  read FIFO push.
- sdram_wr_req  out  1  write request.
- sdram_wr_ack  in  1  write acknowledge.
- sdram_wr_addr  out  24  write address.
- sdram_wr_burst  out  10  write burst length.
- sdram_rd_req  out  1  read request.
- sdram_rd_ack  in  1  read acknowledge.
- sdram_rd_addr  out  24  read address.
- sdram_rd_burst  out  10  read burst length.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0.
  - Write and read pointers load 0; they take min_addr on the first load edge.
  - State IDLE; last_served = RD.
- Combinational outputs:
  - wr_fifo_rdreq = sdram_wr_ack.
  - rd_fifo_wrreq = sdram_rd_ack.
  - sdram_wr_burst = wr_len; sdram_rd_burst = rd_len.
  - sdram_wr_addr and sdram_rd_addr come straight from the pointer registers.
- Eligibility:
  - wr_ok = sdram_init_done && wr_fifo_level >= wr_len.
  - rd_ok = sdram_init_done && rd_en && rd_fifo_level + rd_len <= FIFO_DEPTH.
  - This addition is done at LVL_WIDTH+1 bits.
- State machine:
  - IDLE: both eligible → serve the one not equal to last_served. Otherwise serve whichever is eligible. Move to WR_REQ or RD_REQ; the request is registered and asserts the next cycle.
  - WR_REQ: hold sdram_wr_req = 1 until sdram_wr_ack = 1; drop the request in the same cycle ack is seen, then go to WR_BURST.
  - WR_BURST: wait for the sdram_wr_ack falling edge (registered ack = 1, current ack = 0). On it, advance the write pointer, set last_served = WR, return to IDLE.
  - RD_REQ and RD_BURST: symmetric, using the rd_* signals; last_served = RD.
  - A new request is never asserted in the cycle a burst ends; minimum gap is 1 idle cycle.
  - sdram_wr_req and sdram_rd_req are never high at the same time.
- Pointer advance:
  - next = ptr + len, computed at 25 bits.
  - If next + len > max_addr, then ptr ← min_addr; otherwise ptr ← next.
  - A burst therefore never crosses max_addr.
- Load handling:
  - Edge detect uses one register per load input.
  - A rising edge sets a pending flag for that pointer.
  - The pending flag is applied at the next IDLE cycle for that direction (ptr ← min_addr, flag cleared). It takes priority over any advance in that cycle.
  - A load that arrives mid-burst is therefore deferred until the current burst ends. It is never lost.
- sdram_init_done falling to 0:
  - In IDLE: no new requests are issued.
  - In an active burst: the burst completes normally.
- rst_n asserted mid-burst:
  - All outputs clear immediately.
  - Pointers return to 0.

Test Plan:
1. Reset, init_done = 1, wr_min = 0, wr_max = 2048, wr_len = 512, wr_fifo_level = 600; controller acks 3 cycles after the request, ack held 512 cycles → wr_req falls when ack is seen; wr_fifo_rdreq is high for exactly 512 cycles; wr_addr becomes 512 after the ack falls.
2. Keep wr_fifo_level = 600 for four bursts → addresses 0, 512, 1024, 1536, then wraps to 0. With wr_max = 2000, the 4th burst instead wraps after 1024 (1536 + 512 > 2000).
3. wr_fifo_level = 600, rd_en = 1, rd_fifo_level = 0, rd_len = 256 → grants alternate WR, RD, WR, RD. wr_req and rd_req are never both high, with at least 1 idle cycle between bursts.
4. rd_fifo_level = 800, FIFO_DEPTH = 1024, rd_len = 256 → no rd_req. Drop the level to 768 → rd_req asserts 2 cycles later.
5. Pulse rd_load during a read burst at rd_addr = 768 → that burst completes; the next rd_addr equals rd_min_addr and is not 1024.
6. Assert rst_n low during WR_BURST → all outputs 0 asynchronously; after release, the first request uses address 0.
